// File: rtl/mem_initiator_pkg.sv
// Shared definitions for mem_initiator: default sizes, slot records and an index-width helper.
// Slot records carry the line address only when MEM_RAW_HAZARD_EN is defined.
package mem_initiator_pkg;

    localparam int DEF_NPHYS           = 56;
    localparam int DEF_CACHE_LINE_SIZE = 512;
    localparam int DEF_ACACHE          = $clog2(DEF_CACHE_LINE_SIZE / 8);
    localparam int DEF_RTSIZE          = 8;
    localparam int DEF_WTSIZE          = 5;
    localparam int DEF_NRD             = 4;
    localparam int DEF_NWR             = 4;
    localparam int DEF_CTAG            = 6;
    localparam int DEF_LINE_AW         = DEF_NPHYS - DEF_ACACHE;

    typedef struct packed {
        logic                busy;
        logic [DEF_CTAG-1:0] tag;
    } rd_slot_t;

    typedef struct packed {
        logic                   busy;
        logic [DEF_CTAG-1:0]    tag;
`ifdef MEM_RAW_HAZARD_EN
        logic [DEF_LINE_AW-1:0] addr;
`endif
    } wr_slot_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_slot_alloc.sv
// Transaction slot allocator: busy vector, lowest-free priority encoder, alloc/free ports, full flag.
module mem_slot_alloc
    import mem_initiator_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          alloc,
    input  logic          free,
    input  logic [IW-1:0] free_idx,
    output logic [N-1:0]  busy,
    output logic [IW-1:0] alloc_idx,
    output logic          full
);

    logic [N-1:0] busy_q;
    logic [N-1:0] busy_d;

    always_comb begin
        alloc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_idx = IW'(i);
        end
    end

    // alloc_idx comes from pre-edge state, so it never names the slot being freed this edge.
    always_comb begin
        busy_d = busy_q;
        if (free)  busy_d[free_idx]  = 1'b0;
        if (alloc) busy_d[alloc_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    assign busy = busy_q;
    assign full = &busy_q;

endmodule

// File: rtl/mem_initiator.sv
// Cache-side initiator for the line-granular memory protocol with out-of-order completion.
// Optional MEM_RAW_HAZARD_EN: block reads whose line matches an outstanding write.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int NPHYS            = DEF_NPHYS,
    parameter int CACHE_LINE_SIZE  = DEF_CACHE_LINE_SIZE,
    parameter int ACACHE_LINE_SIZE = $clog2(CACHE_LINE_SIZE / 8),
    parameter int RTSIZE           = DEF_RTSIZE,
    parameter int WTSIZE           = DEF_WTSIZE,
    parameter int NRD              = DEF_NRD,
    parameter int NWR              = DEF_NWR,
    parameter int CTAG             = DEF_CTAG
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              rd_req,
    input  logic [NPHYS-ACACHE_LINE_SIZE-1:0] rd_addr,
    input  logic [CTAG-1:0]                   rd_tag,
    output logic                              rd_ack,
    output logic                              rd_rsp_valid,
    output logic [CACHE_LINE_SIZE-1:0]        rd_rsp_data,
    output logic [CTAG-1:0]                   rd_rsp_tag,
    input  logic                              rd_rsp_ack,
    input  logic                              wr_req,
    input  logic [NPHYS-ACACHE_LINE_SIZE-1:0] wr_addr,
    input  logic [CACHE_LINE_SIZE-1:0]        wr_data,
    input  logic [CTAG-1:0]                   wr_tag,
    output logic                              wr_ack,
    output logic                              wr_done,
    output logic [CTAG-1:0]                   wr_done_tag,
    output logic [NPHYS-ACACHE_LINE_SIZE-1:0] mem_raddr,
    output logic [RTSIZE-1:0]                 mem_raddr_trans,
    output logic                              mem_raddr_req,
    input  logic                              mem_raddr_ack,
    input  logic [CACHE_LINE_SIZE-1:0]        mem_rdata,
    input  logic [RTSIZE-1:0]                 mem_rdata_trans,
    input  logic                              mem_rdata_req,
    output logic                              mem_rdata_ack,
    output logic [NPHYS-ACACHE_LINE_SIZE-1:0] mem_waddr,
    output logic [CACHE_LINE_SIZE-1:0]        mem_wdata,
    output logic [WTSIZE-1:0]                 mem_waddr_trans,
    output logic                              mem_waddr_req,
    input  logic                              mem_waddr_ack,
    input  logic [WTSIZE-1:0]                 mem_wdata_trans,
    input  logic                              mem_wdata_done,
    output logic                              proto_err
);

    localparam int LAW = NPHYS - ACACHE_LINE_SIZE;
    localparam int RIW = idx_w(NRD);
    localparam int WIW = idx_w(NWR);

    logic [NRD-1:0] rd_busy;
    logic [RIW-1:0] rd_alloc_idx, rd_ret_idx;
    logic [NWR-1:0] wr_busy;
    logic [WIW-1:0] wr_alloc_idx, wr_ret_idx;
    logic           rd_full, wr_full, raw_hit;
    logic           rd_fire, wr_fire, rdata_fire, rd_hit, wr_hit, rd_free, wr_free;

    // Control state (reset) and datapath state (no reset)
    logic                       rd_iss_vld_q, rd_iss_vld_d, wr_iss_vld_q, wr_iss_vld_d;
    logic                       rsp_vld_q, rsp_vld_d, wr_done_q, wr_done_d;
    logic                       proto_err_q, proto_err_d;
    logic [LAW-1:0]             rd_iss_addr_q, rd_iss_addr_d, wr_iss_addr_q, wr_iss_addr_d;
    logic [RTSIZE-1:0]          rd_iss_trans_q, rd_iss_trans_d;
    logic [WTSIZE-1:0]          wr_iss_trans_q, wr_iss_trans_d;
    logic [CACHE_LINE_SIZE-1:0] wr_iss_data_q, wr_iss_data_d, rsp_data_q, rsp_data_d;
    logic [CTAG-1:0]            rsp_tag_q, rsp_tag_d, wr_done_tag_q, wr_done_tag_d;
    logic [CTAG-1:0]            rd_tag_q [NRD];
    logic [CTAG-1:0]            rd_tag_d [NRD];
    logic [CTAG-1:0]            wr_tag_q [NWR];
    logic [CTAG-1:0]            wr_tag_d [NWR];

    mem_slot_alloc #(.N(NRD), .IW(RIW)) u_rd_slots (
        .clk, .reset_n, .alloc(rd_fire), .free(rd_free), .free_idx(rd_ret_idx),
        .busy(rd_busy), .alloc_idx(rd_alloc_idx), .full(rd_full)
    );

    mem_slot_alloc #(.N(NWR), .IW(WIW)) u_wr_slots (
        .clk, .reset_n, .alloc(wr_fire), .free(wr_free), .free_idx(wr_ret_idx),
        .busy(wr_busy), .alloc_idx(wr_alloc_idx), .full(wr_full)
    );

    assign rd_ack        = !rd_full && !rd_iss_vld_q && !raw_hit;
    assign wr_ack        = !wr_full && !wr_iss_vld_q;
    assign rd_fire       = rd_req && rd_ack;
    assign wr_fire       = wr_req && wr_ack;
    assign mem_rdata_ack = !rsp_vld_q || rd_rsp_ack;
    assign rdata_fire    = mem_rdata_req && mem_rdata_ack;

    // A response is only trusted when its ID names a slot that is currently busy.
    assign rd_ret_idx = mem_rdata_trans[RIW-1:0];
    assign wr_ret_idx = mem_wdata_trans[WIW-1:0];
    assign rd_hit     = (32'(mem_rdata_trans) < NRD) && rd_busy[rd_ret_idx];
    assign wr_hit     = (32'(mem_wdata_trans) < NWR) && wr_busy[wr_ret_idx];
    assign rd_free    = rdata_fire && rd_hit;
    assign wr_free    = mem_wdata_done && wr_hit;

`ifdef MEM_RAW_HAZARD_EN
    logic [LAW-1:0] wr_slot_addr_q [NWR];
    logic [LAW-1:0] wr_slot_addr_d [NWR];

    always_comb begin
        wr_slot_addr_d = wr_slot_addr_q;
        if (wr_fire) wr_slot_addr_d[wr_alloc_idx] = wr_addr;
        raw_hit = wr_iss_vld_q && (wr_iss_addr_q == rd_addr);
        for (int i = 0; i < NWR; i++) begin
            if (wr_busy[i] && (wr_slot_addr_q[i] == rd_addr)) raw_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) wr_slot_addr_q <= wr_slot_addr_d;
`else
    assign raw_hit = 1'b0;
`endif

    always_comb begin
        rd_iss_vld_d = rd_iss_vld_q;
        if (rd_iss_vld_q && mem_raddr_ack) rd_iss_vld_d = 1'b0;
        if (rd_fire)                       rd_iss_vld_d = 1'b1;
        wr_iss_vld_d = wr_iss_vld_q;
        if (wr_iss_vld_q && mem_waddr_ack) wr_iss_vld_d = 1'b0;
        if (wr_fire)                       wr_iss_vld_d = 1'b1;
        rsp_vld_d = rsp_vld_q;
        if (rsp_vld_q && rd_rsp_ack) rsp_vld_d = 1'b0;
        if (rd_free)                 rsp_vld_d = 1'b1;
        wr_done_d   = wr_free;
        proto_err_d = proto_err_q || (rdata_fire && !rd_hit) || (mem_wdata_done && !wr_hit);
    end

    always_comb begin
        rd_iss_addr_d  = rd_iss_addr_q;
        rd_iss_trans_d = rd_iss_trans_q;
        rd_tag_d       = rd_tag_q;
        wr_iss_addr_d  = wr_iss_addr_q;
        wr_iss_data_d  = wr_iss_data_q;
        wr_iss_trans_d = wr_iss_trans_q;
        wr_tag_d       = wr_tag_q;
        rsp_data_d     = rsp_data_q;
        rsp_tag_d      = rsp_tag_q;
        wr_done_tag_d  = wr_done_tag_q;
        if (rd_fire) begin
            rd_iss_addr_d          = rd_addr;
            rd_iss_trans_d         = RTSIZE'(rd_alloc_idx);
            rd_tag_d[rd_alloc_idx] = rd_tag;
        end
        if (wr_fire) begin
            wr_iss_addr_d          = wr_addr;
            wr_iss_data_d          = wr_data;
            wr_iss_trans_d         = WTSIZE'(wr_alloc_idx);
            wr_tag_d[wr_alloc_idx] = wr_tag;
        end
        if (rd_free) begin
            rsp_data_d = mem_rdata;
            rsp_tag_d  = rd_tag_q[rd_ret_idx];
        end
        if (wr_free) wr_done_tag_d = wr_tag_q[wr_ret_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_iss_vld_q <= 1'b0;
            wr_iss_vld_q <= 1'b0;
            rsp_vld_q    <= 1'b0;
            wr_done_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            rd_iss_vld_q <= rd_iss_vld_d;
            wr_iss_vld_q <= wr_iss_vld_d;
            rsp_vld_q    <= rsp_vld_d;
            wr_done_q    <= wr_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_iss_addr_q  <= rd_iss_addr_d;
        rd_iss_trans_q <= rd_iss_trans_d;
        rd_tag_q       <= rd_tag_d;
        wr_iss_addr_q  <= wr_iss_addr_d;
        wr_iss_data_q  <= wr_iss_data_d;
        wr_iss_trans_q <= wr_iss_trans_d;
        wr_tag_q       <= wr_tag_d;
        rsp_data_q     <= rsp_data_d;
        rsp_tag_q      <= rsp_tag_d;
        wr_done_tag_q  <= wr_done_tag_d;
    end

    assign mem_raddr_req   = rd_iss_vld_q;
    assign mem_raddr       = rd_iss_addr_q;
    assign mem_raddr_trans = rd_iss_trans_q;
    assign mem_waddr_req   = wr_iss_vld_q;
    assign mem_waddr       = wr_iss_addr_q;
    assign mem_wdata       = wr_iss_data_q;
    assign mem_waddr_trans = wr_iss_trans_q;
    assign rd_rsp_valid    = rsp_vld_q;
    assign rd_rsp_data     = rsp_data_q;
    assign rd_rsp_tag      = rsp_tag_q;
    assign wr_done         = wr_done_q;
    assign wr_done_tag     = wr_done_tag_q;
    assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed self-checking bench for mem_initiator (default parameters).
// Covers RAW blocking when compiled with MEM_RAW_HAZARD_EN, independent reads otherwise.
module tb_mem_initiator;

    localparam int LAW   = 50;
    localparam int LINE  = 512;
    localparam int RTS   = 8;
    localparam int WTS   = 5;
    localparam int CTAGW = 6;

    logic             clk, reset_n;
    logic             rd_req, rd_ack, rd_rsp_valid, rd_rsp_ack;
    logic [LAW-1:0]   rd_addr, wr_addr, mem_raddr, mem_waddr;
    logic [CTAGW-1:0] rd_tag, rd_rsp_tag, wr_tag, wr_done_tag;
    logic [LINE-1:0]  rd_rsp_data, wr_data, mem_rdata, mem_wdata;
    logic             wr_req, wr_ack, wr_done;
    logic [RTS-1:0]   mem_raddr_trans, mem_rdata_trans;
    logic             mem_raddr_req, mem_raddr_ack, mem_rdata_req, mem_rdata_ack;
    logic [WTS-1:0]   mem_waddr_trans, mem_wdata_trans;
    logic             mem_waddr_req, mem_waddr_ack, mem_wdata_done, proto_err;

    int errors = 0;
    int checks = 0;

    mem_initiator dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_ack(rd_ack),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_tag(rd_rsp_tag),
        .rd_rsp_ack(rd_rsp_ack),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag), .wr_ack(wr_ack),
        .wr_done(wr_done), .wr_done_tag(wr_done_tag),
        .mem_raddr(mem_raddr), .mem_raddr_trans(mem_raddr_trans), .mem_raddr_req(mem_raddr_req),
        .mem_raddr_ack(mem_raddr_ack),
        .mem_rdata(mem_rdata), .mem_rdata_trans(mem_rdata_trans), .mem_rdata_req(mem_rdata_req),
        .mem_rdata_ack(mem_rdata_ack),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_waddr_trans(mem_waddr_trans),
        .mem_waddr_req(mem_waddr_req), .mem_waddr_ack(mem_waddr_ack),
        .mem_wdata_trans(mem_wdata_trans), .mem_wdata_done(mem_wdata_done),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE-1:0] mkdata(input int n);
        return {16{32'hDEAD0000 ^ 32'(n)}};
    endfunction

    task automatic rd_issue(input logic [LAW-1:0] a, input logic [CTAGW-1:0] t, input int exp_tr);
        rd_req = 1'b1; rd_addr = a; rd_tag = t;
        #1;
        chk("rd_ack_idle", 512'(rd_ack), 512'd1);
        step();
        rd_req = 1'b0;
        chk("raddr_req", 512'(mem_raddr_req), 512'd1);
        chk("raddr_trans", 512'(mem_raddr_trans), 512'(exp_tr));
        chk("raddr", 512'(mem_raddr), 512'(a));
        step();
    endtask

    task automatic rd_return(input int tr, input logic [LINE-1:0] d, input logic [CTAGW-1:0] exp_tag);
        mem_rdata_req = 1'b1; mem_rdata_trans = RTS'(tr); mem_rdata = d;
        #1;
        chk("rdata_ack", 512'(mem_rdata_ack), 512'd1);
        step();
        mem_rdata_req = 1'b0;
        chk("rsp_valid", 512'(rd_rsp_valid), 512'd1);
        chk("rsp_tag", 512'(rd_rsp_tag), 512'(exp_tag));
        chk("rsp_data", rd_rsp_data, d);
        step();
        chk("rsp_taken", 512'(rd_rsp_valid), 512'd0);
    endtask

    initial begin
        reset_n = 1'b1;
        rd_req = 0; rd_addr = '0; rd_tag = '0; rd_rsp_ack = 1'b1;
        wr_req = 0; wr_addr = '0; wr_data = '0; wr_tag = '0;
        mem_raddr_ack = 1'b1; mem_waddr_ack = 1'b1;
        mem_rdata = '0; mem_rdata_trans = '0; mem_rdata_req = 0;
        mem_wdata_trans = '0; mem_wdata_done = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_raddr_req", 512'(mem_raddr_req), 512'd0);
        chk("rst_waddr_req", 512'(mem_waddr_req), 512'd0);
        chk("rst_rsp_valid", 512'(rd_rsp_valid), 512'd0);
        chk("rst_proto_err", 512'(proto_err), 512'd0);
        chk("rst_rd_ack", 512'(rd_ack), 512'd1);
        chk("rst_wr_ack", 512'(wr_ack), 512'd1);
        step(); step();
        reset_n = 1'b1;
        step();

        // Single read, slow memory
        rd_issue(50'h100, 6'd5, 0);
        chk("raddr_drained", 512'(mem_raddr_req), 512'd0);
        repeat (38) step();
        rd_return(0, mkdata(1), 6'd5);

        // Four reads, out-of-order returns, fifth blocked on full slots
        rd_issue(50'h10, 6'd1, 0);
        rd_issue(50'h11, 6'd2, 1);
        rd_issue(50'h12, 6'd3, 2);
        rd_issue(50'h13, 6'd4, 3);
        rd_req = 1'b1; rd_addr = 50'h14; rd_tag = 6'd7;
        #1;
        chk("rd_ack_full", 512'(rd_ack), 512'd0);
        step();
        chk("rd_ack_full2", 512'(rd_ack), 512'd0);
        chk("no_issue_full", 512'(mem_raddr_req), 512'd0);
        step();
        rd_return(3, mkdata(13), 6'd4);
        rd_req = 1'b0;
        chk("fifth_req", 512'(mem_raddr_req), 512'd1);
        chk("fifth_trans", 512'(mem_raddr_trans), 512'd3);
        chk("fifth_addr", 512'(mem_raddr), 512'(50'h14));
        step();
        rd_return(0, mkdata(10), 6'd1);
        rd_return(2, mkdata(12), 6'd3);
        rd_return(1, mkdata(11), 6'd2);
        rd_return(3, mkdata(17), 6'd7);

        // Client back-pressure: second line waits behind the buffered one
        rd_issue(50'h30, 6'd8, 0);
        rd_issue(50'h31, 6'd9, 1);
        rd_rsp_ack = 1'b0;
        mem_rdata_req = 1'b1; mem_rdata_trans = 8'd0; mem_rdata = mkdata(30);
        #1;
        chk("bp_ack_empty", 512'(mem_rdata_ack), 512'd1);
        step();
        mem_rdata_trans = 8'd1; mem_rdata = mkdata(31);
        #1;
        chk("bp_valid", 512'(rd_rsp_valid), 512'd1);
        chk("bp_ack_full", 512'(mem_rdata_ack), 512'd0);
        step();
        chk("bp_hold_tag", 512'(rd_rsp_tag), 512'd8);
        chk("bp_hold_data", rd_rsp_data, mkdata(30));
        chk("bp_ack_still0", 512'(mem_rdata_ack), 512'd0);
        rd_rsp_ack = 1'b1;
        #1;
        chk("bp_ack_through", 512'(mem_rdata_ack), 512'd1);
        step();
        mem_rdata_req = 1'b0;
        chk("bp_second_valid", 512'(rd_rsp_valid), 512'd1);
        chk("bp_second_tag", 512'(rd_rsp_tag), 512'd9);
        chk("bp_second_data", rd_rsp_data, mkdata(31));
        step();
        chk("bp_drained", 512'(rd_rsp_valid), 512'd0);

        // Write outstanding against reads of the same and the next line
        wr_req = 1'b1; wr_addr = 50'h200; wr_data = mkdata(40); wr_tag = 6'd10;
        #1;
        chk("wr_ack_idle", 512'(wr_ack), 512'd1);
        step();
        wr_req = 1'b0;
        chk("waddr_req", 512'(mem_waddr_req), 512'd1);
        chk("waddr", 512'(mem_waddr), 512'(50'h200));
        chk("wdata", mem_wdata, mkdata(40));
        chk("waddr_trans", 512'(mem_waddr_trans), 512'd0);
        step();
        chk("waddr_drained", 512'(mem_waddr_req), 512'd0);
        rd_req = 1'b1; rd_addr = 50'h200; rd_tag = 6'd11;
        #1;
`ifdef MEM_RAW_HAZARD_EN
        chk("raw_block", 512'(rd_ack), 512'd0);
`else
        chk("raw_free", 512'(rd_ack), 512'd1);
`endif
        rd_addr = 50'h201;
        #1;
        chk("raw_other_line", 512'(rd_ack), 512'd1);
        step();
        rd_req = 1'b0;
        chk("raw_other_addr", 512'(mem_raddr), 512'(50'h201));
        chk("raw_other_trans", 512'(mem_raddr_trans), 512'd0);
        step();
        mem_wdata_done = 1'b1; mem_wdata_trans = 5'd0;
        step();
        mem_wdata_done = 1'b0;
        chk("wr_done", 512'(wr_done), 512'd1);
        chk("wr_done_tag", 512'(wr_done_tag), 512'd10);
        rd_req = 1'b1; rd_addr = 50'h200; rd_tag = 6'd12;
        #1;
        chk("raw_released", 512'(rd_ack), 512'd1);
        step();
        rd_req = 1'b0;
        chk("wr_done_pulse", 512'(wr_done), 512'd0);
        chk("raw_read_trans", 512'(mem_raddr_trans), 512'd1);
        step();
        rd_return(0, mkdata(20), 6'd11);
        rd_return(1, mkdata(21), 6'd12);

        // Completion for an unallocated write ID
        chk("perr_before", 512'(proto_err), 512'd0);
        mem_wdata_done = 1'b1; mem_wdata_trans = 5'd3;
        step();
        mem_wdata_done = 1'b0;
        chk("bogus_no_done", 512'(wr_done), 512'd0);
        chk("perr_set", 512'(proto_err), 512'd1);
        step();
        chk("perr_sticky", 512'(proto_err), 512'd1);

        // Asynchronous reset with reads outstanding, issue pending and a buffered line
        rd_issue(50'h40, 6'd20, 0);
        rd_issue(50'h41, 6'd21, 1);
        mem_raddr_ack = 1'b0;
        rd_req = 1'b1; rd_addr = 50'h42; rd_tag = 6'd22;
        step();
        rd_req = 1'b0;
        step();
        chk("pend_raddr_hold", 512'(mem_raddr_req), 512'd1);
        rd_rsp_ack = 1'b0;
        mem_rdata_req = 1'b1; mem_rdata_trans = 8'd0; mem_rdata = mkdata(50);
        step();
        mem_rdata_req = 1'b0;
        chk("pend_rsp_valid", 512'(rd_rsp_valid), 512'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_raddr_req", 512'(mem_raddr_req), 512'd0);
        chk("arst_rsp_valid", 512'(rd_rsp_valid), 512'd0);
        chk("arst_proto_err", 512'(proto_err), 512'd0);
        chk("arst_wr_done", 512'(wr_done), 512'd0);
        chk("arst_rd_ack", 512'(rd_ack), 512'd1);
        chk("arst_wr_ack", 512'(wr_ack), 512'd1);
        chk("arst_rdata_ack", 512'(mem_rdata_ack), 512'd1);
        step();
        reset_n = 1'b1; mem_raddr_ack = 1'b1; rd_rsp_ack = 1'b1;
        #1;
        chk("post_rst_rd_ack", 512'(rd_ack), 512'd1);
        mem_rdata_req = 1'b1; mem_rdata_trans = 8'd1; mem_rdata = mkdata(51);
        step();
        mem_rdata_req = 1'b0;
        chk("stale_perr", 512'(proto_err), 512'd1);
        chk("stale_dropped", 512'(rd_rsp_valid), 512'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
